pattern_pixel_expander: RTL and testbench

Single-clock, parametrised successor to the pixel-clock half of the pattern fetch path. It consumes packed pattern words from a show-ahead FIFO: one header word, then body words per pattern. It expands each word into 1/2/4/8-bit-per-pixel grayscale pixels with horizontal replication, and drives the HDMI pixel bus aligned to the incoming timing. Adds over the previous generation: width/depth parameters, runtime bits-per-pixel, gap-free word reload, explicit underflow handling and status outputs.

---
 rtl/pattern_pkg.sv | 34 +++
 rtl/pattern_pixel_unpack.sv | 35 +++
 rtl/pattern_pixel_expander.sv | 176 +++++++++++++++++
 tb/tb_pattern_pixel_expander.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern pixel expander.
package pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    // Header fields are 32 bits each, packed from the MSB of the word.
    localparam int HDR_FIELD_W = 32;
    localparam int HDR_H_PIX   = 0;
    localparam int HDR_V_PIX   = 1;
    localparam int HDR_TOTAL   = 2;
    localparam int HDR_PAT_NUM = 3;
    localparam int HDR_FILL    = 4;

    // bpp_sel encoding doubles as log2(bits per pixel).
    localparam logic [1:0] BPP_1 = 2'd0;
    localparam logic [1:0] BPP_2 = 2'd1;
    localparam logic [1:0] BPP_4 = 2'd2;
    localparam logic [1:0] BPP_8 = 2'd3;

    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pattern_pixel_unpack.sv
// Picks one pixel out of a packed word (MSB first) and maps it to 8-bit gray.
module pattern_pixel_unpack
    import pattern_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int IDX_W  = 8
) (
    input  logic [DATA_W-1:0] word,
    input  logic [IDX_W-1:0]  pix_idx,
    input  logic [1:0]        bpp,
    input  logic              invert,
    output logic [7:0]        gray
);

    logic [IDX_W+2:0]  bit_ofs;
    logic [DATA_W+6:0] padded;
    logic [7:0]        top;
    logic [7:0]        level;

    // Pad below the LSB so an 8-bit window at the last 1bpp pixel stays in range,
    // then replicate the pixel value to fill the byte.
    always_comb begin
        bit_ofs = {3'b000, pix_idx} << bpp;
        padded  = {word, 7'b0};
        top     = padded[DATA_W + 6 - int'(bit_ofs) -: 8];
        case (bpp)
            BPP_1:   level = {8{top[7]}};
            BPP_2:   level = {4{top[7:6]}};
            BPP_4:   level = {2{top[7:4]}};
            default: level = top;
        endcase
        gray = invert ? ~level : level;
    end

endmodule

// File: rtl/pattern_pixel_expander.sv
// Expands packed pattern words from a show-ahead FIFO into a gray pixel stream
// aligned to the incoming sync timing.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a header word; consumes it when present
// ST_HDR   | header fields held, bpp sampled, counters primed
// ST_LOAD  | awaiting a body word; a word arriving with de emits pixel 0
// ST_SHIFT | emitting pixels from cur_word, reloading at word end
module pattern_pixel_expander
    import pattern_pkg::*;
#(
    parameter int          DATA_W    = 256,
    parameter int          CNT_W     = 24,
    parameter logic [23:0] UFLOW_RGB = 24'hFF0000
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst_n,
    input  logic              pixel_de,
    input  logic              pixel_hs,
    input  logic              pixel_vs,
    input  logic [1:0]        bpp_sel,
    input  logic              invert,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              gen_de,
    output logic              gen_hs,
    output logic              gen_vs,
    output logic [7:0]        gen_r,
    output logic [7:0]        gen_g,
    output logic [7:0]        gen_b,
    output logic              busy,
    output logic              pat_done,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int IDX_W     = ceil_log2(DATA_W);
    localparam int TOTAL_MSB = DATA_W - 1 - HDR_TOTAL * HDR_FIELD_W;
    localparam int PAT_MSB   = DATA_W - 1 - HDR_PAT_NUM * HDR_FIELD_W;
    localparam int FILL_MSB  = DATA_W - 1 - HDR_FILL * HDR_FIELD_W;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  total, pat_left, fill_last, pix_rem, fill_cnt, fill_hdr;
    logic [1:0]        bpp;
    logic [DATA_W-1:0] cur_word, word;
    logic [IDX_W-1:0]  pix_idx, ppw_last;
    logic [7:0]        gray;
    logic [23:0]       rgb;
    logic              have_word, emit, uflow_evt, fill_term, pat_end, word_end;
    logic              reload, hdr_empty, word_take;

    // In LOAD the arriving FIFO word is used directly so a pattern or word
    // boundary does not cost a pixel when data is available.
    always_comb begin
        fill_hdr  = CNT_W'(in_data[FILL_MSB -: HDR_FIELD_W]);
        ppw_last  = IDX_W'((DATA_W >> bpp) - 1);
        have_word = (state == ST_SHIFT) || (state == ST_LOAD && in_valid);
        word      = (state == ST_SHIFT) ? cur_word : in_data;
        emit      = have_word && pixel_de;
        uflow_evt = (state == ST_LOAD) && !in_valid && pixel_de;
        fill_term = (fill_cnt == fill_last);
        pat_end   = emit && fill_term && (pix_rem == CNT_W'(1));
        word_end  = emit && fill_term && ((pix_idx == ppw_last) || (pix_rem == CNT_W'(1)));
        reload    = word_end && !pat_end && (state == ST_SHIFT) && in_valid;
        hdr_empty = (pat_left == '0) || (total == '0);
    end

    pattern_pixel_unpack #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_unpack (
        .word    (word),
        .pix_idx (pix_idx),
        .bpp     (bpp),
        .invert  (invert),
        .gray    (gray)
    );

    // Next-state and FIFO read request.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = in_valid;
                if (in_valid) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                state_nxt = hdr_empty ? ST_IDLE : ST_LOAD;
            end
            ST_LOAD, ST_SHIFT: begin
                in_ready = (state == ST_LOAD) ? in_valid : reload;
                if (pat_end)
                    state_nxt = (pat_left == CNT_W'(1)) ? ST_IDLE : ST_LOAD;
                else if (word_end)
                    state_nxt = reload ? ST_SHIFT : ST_LOAD;
                else if (have_word)
                    state_nxt = ST_SHIFT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign word_take = in_ready && (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // State register.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    // Header capture, word buffer and pixel/replica/pattern counters.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            total     <= '0;
            pat_left  <= '0;
            fill_last <= '0;
            bpp       <= '0;
            cur_word  <= '0;
            pix_idx   <= '0;
            fill_cnt  <= '0;
            pix_rem   <= '0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                total     <= CNT_W'(in_data[TOTAL_MSB -: HDR_FIELD_W]);
                pat_left  <= CNT_W'(in_data[PAT_MSB -: HDR_FIELD_W]);
                fill_last <= (fill_hdr == '0) ? '0 : fill_hdr - CNT_W'(1);
            end
            if (state == ST_HDR) begin
                bpp      <= bpp_sel;
                pix_rem  <= total;
                pix_idx  <= '0;
                fill_cnt <= '0;
            end
            if (word_take) cur_word <= in_data;
            if (emit) begin
                if (fill_term) begin
                    fill_cnt <= '0;
                    pix_idx  <= word_end ? '0 : pix_idx + 1'b1;
                    pix_rem  <= pat_end ? total : pix_rem - CNT_W'(1);
                end else begin
                    fill_cnt <= fill_cnt + CNT_W'(1);
                end
            end
            if (pat_end) pat_left <= pat_left - CNT_W'(1);
        end
    end

    // Registered pixel bus, completion pulse and sticky underflow flag.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            gen_de    <= 1'b0;
            gen_hs    <= 1'b1;
            gen_vs    <= 1'b1;
            rgb       <= '0;
            pat_done  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            gen_de   <= pixel_de;
            gen_hs   <= pixel_hs;
            gen_vs   <= pixel_vs;
            rgb      <= emit ? {3{gray}} : (uflow_evt ? UFLOW_RGB : 24'h000000);
            pat_done <= pat_end || (state == ST_HDR && hdr_empty);
            if (err_clr)        underflow <= 1'b0;
            else if (uflow_evt) underflow <= 1'b1;
        end
    end

    assign gen_r = rgb[23:16];
    assign gen_g = rgb[15:8];
    assign gen_b = rgb[7:0];

endmodule

// File: tb/tb_pattern_pixel_expander.sv
// Directed bench for pattern_pixel_expander with a queue-based FIFO model.
module tb_pattern_pixel_expander;

    localparam int DATA_W = 256;

    logic              pixel_clk = 1'b0;
    logic              pixel_rst_n;
    logic              pixel_de, pixel_hs, pixel_vs;
    logic [1:0]        bpp_sel;
    logic              invert;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              gen_de, gen_hs, gen_vs;
    logic [7:0]        gen_r, gen_g, gen_b;
    logic              busy, pat_done, underflow, err_clr;

    pattern_pixel_expander #(
        .DATA_W    (DATA_W),
        .CNT_W     (24),
        .UFLOW_RGB (24'hFF0000)
    ) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst_n (pixel_rst_n),
        .pixel_de    (pixel_de),
        .pixel_hs    (pixel_hs),
        .pixel_vs    (pixel_vs),
        .bpp_sel     (bpp_sel),
        .invert      (invert),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gen_de      (gen_de),
        .gen_hs      (gen_hs),
        .gen_vs      (gen_vs),
        .gen_r       (gen_r),
        .gen_g       (gen_g),
        .gen_b       (gen_b),
        .busy        (busy),
        .pat_done    (pat_done),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [1:0]  bpp;
        logic        inv;
        logic [15:0] top;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    vec_t              vecs[7];
    logic [DATA_W-1:0] fifo[$];
    logic [23:0]       pix_q[$];
    int                pd_t[$];
    int                checks = 0;
    int                errors = 0;
    int                hs_cnt = 0;
    int                pd_cnt = 0;
    int                tick_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] hdr(input int total, input int pat, input int fill);
        return {32'd0, 32'd0, 32'(total), 32'(pat), 32'(fill), 96'd0};
    endfunction

    function automatic logic [23:0] pix(input int i);
        if (i < pix_q.size()) return pix_q[i];
        return 24'hxxxxxx;
    endfunction

    task automatic refresh();
        in_valid = (fifo.size() > 0);
        in_data  = in_valid ? fifo[0] : '0;
    endtask

    task automatic clr();
        pix_q.delete();
        pd_t.delete();
        hs_cnt = 0;
        pd_cnt = 0;
    endtask

    // One clock: handshake seen before the edge, outputs collected after it.
    task automatic tick();
        bit took;
        #1;
        took = in_valid && in_ready;
        @(negedge pixel_clk);
        tick_no++;
        if (took) begin
            fifo.delete(0);
            hs_cnt++;
        end
        if (gen_de) pix_q.push_back({gen_r, gen_g, gen_b});
        if (pat_done) begin
            pd_cnt++;
            pd_t.push_back(tick_no);
        end
        refresh();
    endtask

    task automatic run_de(input int n);
        pixel_de = 1'b1;
        repeat (n) tick();
        pixel_de = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{2'd0, 1'b1, 16'h8000, 8'h00, 8'hFF};
        vecs[1] = '{2'd0, 1'b0, 16'h4000, 8'h00, 8'hFF};
        vecs[2] = '{2'd1, 1'b0, 16'h9000, 8'hAA, 8'h55};
        vecs[3] = '{2'd2, 1'b0, 16'hC300, 8'hCC, 8'h33};
        vecs[4] = '{2'd2, 1'b1, 16'hA500, 8'h55, 8'hAA};
        vecs[5] = '{2'd3, 1'b0, 16'h12F0, 8'h12, 8'hF0};
        vecs[6] = '{2'd3, 1'b1, 16'h12F0, 8'hED, 8'h0F};

        pixel_rst_n = 1'b0;
        pixel_de = 1'b0; pixel_hs = 1'b0; pixel_vs = 1'b0;
        bpp_sel = 2'd0; invert = 1'b0; err_clr = 1'b0;
        refresh();
        #12;
        check("rst_busy", busy, 0);
        check("rst_gen_de", gen_de, 0);
        check("rst_gen_hs", gen_hs, 1);
        check("rst_gen_vs", gen_vs, 1);
        check("rst_rgb", {gen_r, gen_g, gen_b}, 0);
        check("rst_pat_done", pat_done, 0);
        check("rst_underflow", underflow, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge pixel_clk);
        pixel_rst_n = 1'b1;
        tick();
        check("hs_follows", gen_hs, 0);

        // Gray mapping table: two-pixel patterns, one per bpp/invert case.
        for (int v = 0; v < 7; v++) begin
            clr();
            bpp_sel = vecs[v].bpp;
            invert  = vecs[v].inv;
            fifo.push_back(hdr(2, 1, 0));
            fifo.push_back({vecs[v].top, 240'd0});
            refresh();
            repeat (4) tick();
            run_de(2);
            check($sformatf("vec%0d_count", v), pix_q.size(), 2);
            check($sformatf("vec%0d_pix0", v), pix(0), {3{vecs[v].e0}});
            check($sformatf("vec%0d_pix1", v), pix(1), {3{vecs[v].e1}});
            check($sformatf("vec%0d_done", v), pd_cnt, 1);
        end

        // 1bpp inverted, two full words.
        clr();
        bpp_sel = 2'd0; invert = 1'b1;
        fifo.push_back(hdr(512, 1, 0));
        fifo.push_back({2'b10, 254'd0});
        fifo.push_back({DATA_W{1'b1}});
        refresh();
        repeat (4) tick();
        run_de(512);
        check("t1_count", pix_q.size(), 512);
        check("t1_pix0", pix(0), 24'h000000);
        check("t1_pix1", pix(1), 24'hFFFFFF);
        check("t1_pix255", pix(255), 24'hFFFFFF);
        check("t1_pix256", pix(256), 24'h000000);
        check("t1_pix511", pix(511), 24'h000000);
        check("t1_reads", hs_cnt, 3);
        check("t1_done", pd_cnt, 1);
        check("t1_idle", busy, 0);

        // 1bpp, partial last word, each pixel repeated 3 times.
        clr();
        invert = 1'b0;
        fifo.push_back(hdr(300, 1, 3));
        fifo.push_back('0);
        fifo.push_back({1'b1, 42'd0, 1'b1, 212'd0});
        refresh();
        repeat (4) tick();
        run_de(900);
        check("t2_count", pix_q.size(), 900);
        check("t2_pix767", pix(767), 24'h000000);
        check("t2_pix768", pix(768), 24'hFFFFFF);
        check("t2_pix770", pix(770), 24'hFFFFFF);
        check("t2_pix771", pix(771), 24'h000000);
        check("t2_pix896", pix(896), 24'h000000);
        check("t2_pix897", pix(897), 24'hFFFFFF);
        check("t2_pix899", pix(899), 24'hFFFFFF);
        check("t2_reads", hs_cnt, 3);
        check("t2_done", pd_cnt, 1);
        check("t2_idle", busy, 0);

        // Two patterns from one header, continuous de.
        clr();
        fifo.push_back(hdr(256, 2, 0));
        fifo.push_back('0);
        fifo.push_back({DATA_W{1'b1}});
        refresh();
        repeat (4) tick();
        run_de(512);
        check("t4_count", pix_q.size(), 512);
        check("t4_pix255", pix(255), 24'h000000);
        check("t4_pix256", pix(256), 24'hFFFFFF);
        check("t4_pix511", pix(511), 24'hFFFFFF);
        check("t4_reads", hs_cnt, 3);
        check("t4_done", pd_cnt, 2);
        check("t4_gap", (pd_t.size() == 2) ? pd_t[1] - pd_t[0] : -1, 256);
        check("t4_idle", busy, 0);

        // Underflow at a word boundary, clear priority, resume at same index.
        clr();
        fifo.push_back(hdr(512, 1, 0));
        fifo.push_back('0);
        refresh();
        repeat (4) tick();
        pixel_de = 1'b1;
        repeat (256 + 4) tick();
        check("t5_flag_set", underflow, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_clr_priority", underflow, 0);
        fifo.push_back({1'b1, 255'd0});
        refresh();
        run_de(256);
        check("t5_count", pix_q.size(), 517);
        check("t5_pix255", pix(255), 24'h000000);
        check("t5_uf_first", pix(256), 24'hFF0000);
        check("t5_uf_last", pix(260), 24'hFF0000);
        check("t5_resume", pix(261), 24'hFFFFFF);
        check("t5_next", pix(262), 24'h000000);
        check("t5_flag_after", underflow, 0);
        check("t5_done", pd_cnt, 1);

        // Empty pattern count: header only, immediate completion.
        clr();
        fifo.push_back(hdr(64, 0, 0));
        refresh();
        repeat (4) tick();
        check("t7_reads", hs_cnt, 1);
        check("t7_done", pd_cnt, 1);
        check("t7_idle", busy, 0);

        // Reset in the middle of a pattern.
        clr();
        fifo.push_back(hdr(512, 1, 0));
        fifo.push_back({DATA_W{1'b1}});
        fifo.push_back({DATA_W{1'b1}});
        refresh();
        repeat (4) tick();
        pixel_de = 1'b1;
        repeat (10) tick();
        check("t6_busy_before", busy, 1);
        check("t6_rgb_before", {gen_r, gen_g, gen_b}, 24'hFFFFFF);
        pixel_rst_n = 1'b0;
        pixel_de = 1'b0;
        fifo.delete();
        refresh();
        #1;
        check("t6_busy", busy, 0);
        check("t6_gen_de", gen_de, 0);
        check("t6_gen_hs", gen_hs, 1);
        check("t6_gen_vs", gen_vs, 1);
        check("t6_rgb", {gen_r, gen_g, gen_b}, 0);
        @(negedge pixel_clk);
        pixel_rst_n = 1'b1;
        repeat (3) tick();
        check("t6_idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
